// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_last;
  logic [WIDTH:0]   w_acc_ext;
  logic [WIDTH-1:0] w_acc_next;

  assign w_fa_s     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_fa_co    = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // Shift right inserting the new bit at the MSB; works for WIDTH=1 too.
  assign w_acc_ext  = {w_fa_s, r_acc};
  assign w_acc_next = w_acc_ext[WIDTH:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_fa_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          // On the MSB bit the pre-update carry is the carry into the MSB.
          if (w_last) begin
            r_sum      <= w_acc_next;
            r_c_out    <= w_fa_co;
            r_overflow <= r_carry ^ w_fa_co;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences a single one-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock. It accepts operands with a start/busy/done handshake and holds the result for downstream logic. Datapath cost is one full-adder cell plus shift registers, so it replaces a WIDTH-cell ripple chain where throughput is not critical.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
c_in  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while an operation is in RUN or DONE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result, held until the next completion
c_out  output  1  registered carry-out of the MSB
overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low. When rst_n is sampled low at a rising edge:
  - state goes to IDLE;
  - busy=0, done=0, sum=0, c_out=0, overflow=0;
  - operand shift registers, carry register and counter go to 0.
- Reset mid-operation aborts the addition. No done pulse is produced and no partial result is written.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE, start=1 at edge k: load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, acc<=0; go to RUN. busy is high from the cycle after edge k.
  - IDLE, start=0: stay in IDLE. Outputs hold their values.
  - RUN, each edge:
    - FA inputs are a_sh[0], b_sh[0], carry.
    - acc shifts right, inserting the FA sum bit at the MSB.
    - a_sh and b_sh shift right with zero fill.
    - carry <= FA carry-out. cnt <= cnt+1.
    - When cnt==WIDTH-1 the pre-update carry is latched as the MSB carry-in (cin_msb).
  - RUN, at the edge where cnt==WIDTH-1: go to DONE. sum <= final acc value (including this edge's bit), c_out <= FA carry-out, overflow <= cin_msb XOR FA carry-out.
  - DONE: done=1 for exactly one cycle, busy=1. Next edge goes to IDLE unconditionally.
- Latency:
  - done is high in the cycle following edge k+WIDTH (k = accepting edge).
  - Back-to-back issue: next start accepted at edge k+WIDTH+2 at the earliest. Initiation interval is WIDTH+2 cycles.
- start handling: ignored (not queued) while busy=1, including in DONE. Operand inputs are don't-care except on the accepting edge.
- sum, c_out and overflow change only on the edge entering DONE or on reset. They are stable throughout RUN and hold the previous result.
- Arithmetic: the result is modulo 2**WIDTH; c_out is the unsigned carry.
- WIDTH=1: single RUN cycle; cin_msb = c_in.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, start at edge k -> done pulse in the cycle after edge k+8; sum=0x96, c_out=0, overflow=1; busy high for 9 cycles.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0. Then a=0x7F, b=0x00, c_in=1 -> sum=0x80, c_out=0, overflow=1.
- Assert start with a=0x11, b=0x22 during RUN of a 0x01+0x01 operation -> ignored; sum=0x02, a single done pulse only. Next start accepted no earlier than edge k+10.
- rst_n low for 1 cycle at edge k+4 of an operation -> busy=0, sum=0, c_out=0, overflow=0 the next cycle; no done pulse. A new start then completes normally.
- Idle hold: after a result, keep start=0 for 20 cycles -> sum, c_out and overflow unchanged, done stays 0.
- WIDTH=1: a=1, b=1, c_in=1 -> done after 1 RUN cycle; sum=1, c_out=1, overflow=0. Compare 500 random WIDTH=8 operations against a reference model of a+b+c_in.
